rbcp_arbiter: RTL

Shares the single RBCP register bus, which feeds the read/write register banks, between two masters. M0 is the SiTCP RBCP port for host access. M1 is the on-board initialisation/auto-configuration sequencer, for example DAC and ROFS preload after power-up.
Arbitration is round-robin with a one-deep request latch per master. Slave responses are routed back to the granted master only.
A missing slave ACK is resolved by a watchdog, so a master never hangs.

---
 rtl/rbcp_arbiter_if.sv | 45 ++++
 rtl/rbcp_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rbcp_arbiter_if.sv
// RBCP bus bundle shared by the two masters, the arbiter and the slave bus.
// The slave modport is the arbiter's view; master is the driving environment.
interface rbcp_arbiter_if;
    logic        M0_ACT;
    logic [31:0] M0_ADDR;
    logic [7:0]  M0_WD;
    logic        M0_WE;
    logic        M0_RE;
    logic        M0_ACK;
    logic [7:0]  M0_RD;
    logic        M1_ACT;
    logic [31:0] M1_ADDR;
    logic [7:0]  M1_WD;
    logic        M1_WE;
    logic        M1_RE;
    logic        M1_ACK;
    logic [7:0]  M1_RD;
    logic        S_ACT;
    logic [31:0] S_ADDR;
    logic [7:0]  S_WD;
    logic        S_WE;
    logic        S_RE;
    logic        S_ACK;
    logic [7:0]  S_RD;
    logic [1:0]  GRANT;
    logic [15:0] TIMEOUT_COUNT;

    modport slave (
        input  M0_ACT, M0_ADDR, M0_WD, M0_WE, M0_RE,
        input  M1_ACT, M1_ADDR, M1_WD, M1_WE, M1_RE,
        input  S_ACK, S_RD,
        output M0_ACK, M0_RD, M1_ACK, M1_RD,
        output S_ACT, S_ADDR, S_WD, S_WE, S_RE,
        output GRANT, TIMEOUT_COUNT
    );

    modport master (
        output M0_ACT, M0_ADDR, M0_WD, M0_WE, M0_RE,
        output M1_ACT, M1_ADDR, M1_WD, M1_WE, M1_RE,
        output S_ACK, S_RD,
        input  M0_ACK, M0_RD, M1_ACK, M1_RD,
        input  S_ACT, S_ADDR, S_WD, S_WE, S_RE,
        input  GRANT, TIMEOUT_COUNT
    );
endinterface

// File: rtl/rbcp_arbiter.sv
// Round-robin arbiter sharing one RBCP register bus between the SiTCP host
// port (M0) and the auto-configuration sequencer (M1), with ACK watchdog.
module rbcp_arbiter #(
    parameter int TIMEOUT = 255
) (
    input logic          CLK,
    input logic          RST,
    rbcp_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, DONE} state_t;

    // Expiry fires on the clock where the watchdog steps onto TIMEOUT-1.
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 2);

    state_t state_q, state_d;
    logic owner_q, owner_d;
    logic [1:0] pend_q, pend_d;
    logic [1:0][31:0] addr_q, addr_d;
    logic [1:0][7:0] wd_q, wd_d;
    logic [1:0] wr_q, wr_d;
    logic xfer_wr_q, xfer_wr_d;
    logic [15:0] wdog_q, wdog_d;
    logic [7:0] rdat_q, rdat_d;
    logic [15:0] tcnt_q, tcnt_d;

    logic s_act_q, s_act_d;
    logic [31:0] s_addr_q, s_addr_d;
    logic [7:0] s_wd_q, s_wd_d;
    logic s_we_q, s_we_d;
    logic s_re_q, s_re_d;
    logic [1:0] ack_q, ack_d;
    logic [1:0][7:0] rd_q, rd_d;
    logic [1:0] grant_q, grant_d;

    logic [1:0] act_in;
    logic [1:0] stb_in;
    logic [1:0] we_in;
    logic [1:0][31:0] addr_in;
    logic [1:0][7:0] wd_in;
    logic [1:0] req;

    assign act_in  = {bus.M1_ACT, bus.M0_ACT};
    assign we_in   = {bus.M1_WE, bus.M0_WE};
    assign stb_in  = we_in | {bus.M1_RE, bus.M0_RE};
    assign addr_in = {bus.M1_ADDR, bus.M0_ADDR};
    assign wd_in   = {bus.M1_WD, bus.M0_WD};
    assign req     = pend_q & act_in;

    always_comb begin
        pend_d = pend_q;
        addr_d = addr_q;
        wd_d   = wd_q;
        wr_d   = wr_q;
        for (int i = 0; i < 2; i++) begin
            if (!pend_q[i] && stb_in[i]) begin
                pend_d[i] = 1'b1;
                addr_d[i] = addr_in[i];
                wd_d[i]   = wd_in[i];
                wr_d[i]   = we_in[i];
            end else if (pend_q[i] && !act_in[i]) begin
                pend_d[i] = 1'b0;
            end
        end
        if (state_q == ISSUE) begin
            pend_d[owner_q] = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        xfer_wr_d = xfer_wr_q;
        wdog_d    = wdog_q;
        rdat_d    = rdat_q;
        tcnt_d    = tcnt_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = ISSUE;
                    owner_d = (&req) ? ~owner_q : req[1];
                end
            end
            ISSUE: begin
                state_d   = WAIT_ACK;
                wdog_d    = 16'd0;
                xfer_wr_d = wr_q[owner_q];
            end
            WAIT_ACK: begin
                wdog_d = wdog_q + 16'd1;
                if (bus.S_ACK) begin
                    rdat_d  = xfer_wr_q ? 8'h00 : bus.S_RD;
                    state_d = DONE;
                end else if (wdog_q == WD_LAST) begin
                    rdat_d  = xfer_wr_q ? 8'h00 : 8'hFF;
                    state_d = DONE;
                    if (tcnt_q != 16'hFFFF) begin
                        tcnt_d = tcnt_q + 16'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus outputs are decoded from the current state and registered.
    always_comb begin
        s_act_d  = (state_q == ISSUE) || (state_q == WAIT_ACK);
        s_addr_d = '0;
        s_wd_d   = '0;
        s_we_d   = 1'b0;
        s_re_d   = 1'b0;
        ack_d    = '0;
        rd_d     = '0;
        grant_d  = '0;
        unique case (state_q)
            ISSUE: begin
                s_addr_d = addr_q[owner_q];
                s_wd_d   = wd_q[owner_q];
                s_we_d   = wr_q[owner_q];
                s_re_d   = !wr_q[owner_q];
                grant_d  = owner_q ? 2'b10 : 2'b01;
            end
            WAIT_ACK: begin
                s_addr_d = s_addr_q;
                s_wd_d   = s_wd_q;
                grant_d  = grant_q;
            end
            DONE: begin
                ack_d[owner_q] = 1'b1;
                rd_d[owner_q]  = rdat_q;
                grant_d        = grant_q;
            end
            default: begin
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            owner_q   <= 1'b1;
            pend_q    <= '0;
            addr_q    <= '0;
            wd_q      <= '0;
            wr_q      <= '0;
            xfer_wr_q <= 1'b0;
            wdog_q    <= '0;
            rdat_q    <= '0;
            tcnt_q    <= '0;
            s_act_q   <= 1'b0;
            s_addr_q  <= '0;
            s_wd_q    <= '0;
            s_we_q    <= 1'b0;
            s_re_q    <= 1'b0;
            ack_q     <= '0;
            rd_q      <= '0;
            grant_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            pend_q    <= pend_d;
            addr_q    <= addr_d;
            wd_q      <= wd_d;
            wr_q      <= wr_d;
            xfer_wr_q <= xfer_wr_d;
            wdog_q    <= wdog_d;
            rdat_q    <= rdat_d;
            tcnt_q    <= tcnt_d;
            s_act_q   <= s_act_d;
            s_addr_q  <= s_addr_d;
            s_wd_q    <= s_wd_d;
            s_we_q    <= s_we_d;
            s_re_q    <= s_re_d;
            ack_q     <= ack_d;
            rd_q      <= rd_d;
            grant_q   <= grant_d;
        end
    end

    assign bus.S_ACT         = s_act_q;
    assign bus.S_ADDR        = s_addr_q;
    assign bus.S_WD          = s_wd_q;
    assign bus.S_WE          = s_we_q;
    assign bus.S_RE          = s_re_q;
    assign bus.M0_ACK        = ack_q[0];
    assign bus.M1_ACK        = ack_q[1];
    assign bus.M0_RD         = rd_q[0];
    assign bus.M1_RD         = rd_q[1];
    assign bus.GRANT         = grant_q;
    assign bus.TIMEOUT_COUNT = tcnt_q;

endmodule
